// File: rtl/command.sv
// Byte-level command processor: parses {SYNC, CMD, ARG, CHK} frames from the UART
// receiver, drives a 5-bit LED register and returns a {STATUS, DATA} response.
module command #(
   parameter logic [7:0] SYNC     = 8'hA5,
   parameter int          TIMEOUT  = 120000,
   parameter logic [4:0] LED_INIT = 5'b10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_stb,
   input  logic [7:0] s_dat,
   output logic       s_rdy,
   output logic       m_stb,
   output logic [7:0] m_dat,
   input  logic       m_rdy,
   output logic [4:0] led,
   output logic       busy
);

   localparam int            CW     = $clog2(TIMEOUT);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {HUNT, CMD, ARG, CHK, EXEC, RSP0, RSP1} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    cmd_r, arg_r, chk_r, data_r;
   logic [15:0]   result;
   logic          s_acc;
   logic          led_wr;

   // First matching rule decides; returns {status, data}.
   function automatic logic [15:0] evaluate(input logic [7:0] c, input logic [7:0] a,
                                            input logic [7:0] k, input logic [4:0] l);
      if (k != (c ^ a))  return {8'hE1, k};
      else if (c == 8'h01) return {8'h00, 3'b000, a[4:0]};
      else if (c == 8'h02) return {8'h00, 3'b000, l};
      else if (c == 8'h03) return {8'h00, a};
      else                 return {8'hE2, c};
   endfunction

   assign s_acc  = s_stb && s_rdy;
   assign result = evaluate(cmd_r, arg_r, chk_r, led);
   assign led_wr = (chk_r == (cmd_r ^ arg_r)) && (cmd_r == 8'h01);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= HUNT;
         s_rdy <= 1'b1;
         m_stb <= 1'b0;
         m_dat <= 8'h00;
         led   <= LED_INIT;
         busy  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            HUNT: begin
               cnt <= '0;
               if (s_acc && s_dat == SYNC) begin
                  state <= CMD;
                  busy  <= 1'b1;
               end
            end
            CMD, ARG, CHK: begin
               // An accepted byte takes priority over an expiring timeout.
               if (s_acc) begin
                  cnt <= '0;
                  if (state == CMD) begin
                     cmd_r <= s_dat;
                     state <= ARG;
                  end else if (state == ARG) begin
                     arg_r <= s_dat;
                     state <= CHK;
                  end else begin
                     chk_r <= s_dat;
                     state <= EXEC;
                     s_rdy <= 1'b0;
                  end
               end else if (cnt == T_LAST) begin
                  cnt   <= '0;
                  state <= HUNT;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EXEC: begin
               if (led_wr) led <= arg_r[4:0];
               m_stb  <= 1'b1;
               m_dat  <= result[15:8];
               data_r <= result[7:0];
               state  <= RSP0;
            end
            RSP0: begin
               if (m_rdy) begin
                  m_dat <= data_r;
                  state <= RSP1;
               end
            end
            RSP1: begin
               if (m_rdy) begin
                  m_stb <= 1'b0;
                  s_rdy <= 1'b1;
                  busy  <= 1'b0;
                  state <= HUNT;
               end
            end
            default: begin
               state <= HUNT;
               s_rdy <= 1'b1;
               m_stb <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_command.sv
// Bench for command: directed scenarios plus randomized frames checked against a
// frame-level model of the LED register and the response rules.
module tb_command;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_stb = 1'b0;
   logic [7:0] s_dat = 8'h00;
   logic       m_rdy = 1'b0;
   logic       s_rdy, m_stb, busy;
   logic [7:0] m_dat;
   logic [4:0] led;

   int         tests = 0;
   int         fails = 0;
   logic [4:0] led_m;

   command #(.SYNC(8'hA5), .TIMEOUT(TO), .LED_INIT(5'b10000)) dut (
      .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
      .m_stb(m_stb), .m_dat(m_dat), .m_rdy(m_rdy), .led(led), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      s_stb = 1'b1;
      s_dat = b;
      while (s_rdy !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n == 200) check("s_rdy_wait", 32'(s_rdy), 32'd1);
      tick();
      s_stb = 1'b0;
      s_dat = 8'($urandom);
   endtask

   task automatic recv_byte(input string tag, input logic [7:0] exp, input int stall);
      int n = 0;
      m_rdy = 1'b0;
      while (m_stb !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_stb"}, 32'(m_stb), 32'd1);
      check(tag, 32'(m_dat), 32'(exp));
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, "_hold"}, 32'({m_stb, s_rdy, m_dat}), 32'({2'b10, exp}));
      end
      m_rdy = 1'b1;
      tick();
      m_rdy = 1'b0;
   endtask

   // Full frame: expected response and LED value come from the command rules.
   task automatic do_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                           input int stall);
      logic [7:0] st, dt;
      logic [4:0] led_new;
      led_new = led_m;
      if (k != (c ^ a)) begin
         st = 8'hE1; dt = k;
      end else if (c == 8'h01) begin
         st = 8'h00; dt = {3'b000, a[4:0]}; led_new = a[4:0];
      end else if (c == 8'h02) begin
         st = 8'h00; dt = {3'b000, led_m};
      end else if (c == 8'h03) begin
         st = 8'h00; dt = a;
      end else begin
         st = 8'hE2; dt = c;
      end
      send_byte(8'hA5);
      send_byte(c);
      send_byte(a);
      send_byte(k);
      check("exec_ctl", 32'({s_rdy, m_stb, busy}), 32'(3'b001));
      check("exec_led", 32'(led), 32'(led_m));
      tick();
      led_m = led_new;
      check("rsp_led", 32'(led), 32'(led_m));
      check("rsp_stb", 32'(m_stb), 32'd1);
      recv_byte("status", st, stall);
      recv_byte("data", dt, 0);
      check("idle_ctl", 32'({m_stb, s_rdy, busy}), 32'(3'b010));
   endtask

   initial begin
      logic [7:0] c, a, k, g;
      tick(2);
      rst = 1'b1;
      led_m = 5'b10000;
      check("reset_state", 32'({s_rdy, m_stb, busy, m_dat, led}),
            32'({3'b100, 8'h00, 5'b10000}));

      // Write, read-back with long backpressure, checksum and unknown-command errors.
      do_frame(8'h01, 8'h0A, 8'h0B, 0);
      check("t1_led", 32'(led), 32'(5'b01010));
      do_frame(8'h02, 8'h00, 8'h02, 50);
      do_frame(8'h01, 8'h0A, 8'h00, 0);
      do_frame(8'h7F, 8'h00, 8'h7F, 0);

      // Non-SYNC bytes in HUNT are dropped.
      send_byte(8'h00);
      send_byte(8'hFF);
      check("hunt_discard", 32'({busy, s_rdy}), 32'(2'b01));
      do_frame(8'h03, 8'h5A, 8'h59, 0);

      // Timeout: busy holds through TO-1 idle edges, drops on the TO-th.
      send_byte(8'hA5);
      send_byte(8'h01);
      tick(TO - 1);
      check("to_before", 32'(busy), 32'd1);
      tick();
      check("to_after", 32'({busy, m_stb, s_rdy}), 32'(3'b001));
      check("to_led", 32'(led), 32'(led_m));
      do_frame(8'h03, 8'h11, 8'h12, 0);

      // A byte arriving on the timeout edge is still taken.
      send_byte(8'hA5);
      tick(TO - 1);
      send_byte(8'h03);
      send_byte(8'h44);
      send_byte(8'h47);
      tick();
      check("edge_byte_stb", 32'({m_stb, m_dat}), 32'({1'b1, 8'h00}));
      recv_byte("edge_status", 8'h00, 0);
      recv_byte("edge_data", 8'h44, 0);

      // Reset in RSP0 abandons the response.
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h03);
      send_byte(8'h02);
      tick();
      check("pre_rst_stb", 32'(m_stb), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      led_m = 5'b10000;
      check("mid_rst", 32'({m_stb, s_rdy, busy, m_dat, led}),
            32'({3'b010, 8'h00, 5'b10000}));
      do_frame(8'h02, 8'h00, 8'h02, 0);

      // Randomized frames with leading junk and response stalls.
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
         end
         case ($urandom_range(0, 4))
            0: c = 8'h01;
            1: c = 8'h02;
            2: c = 8'h03;
            default: c = 8'($urandom);
         endcase
         a = 8'($urandom);
         k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ a);
         do_frame(c, a, k, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
